// File: rtl/o_feature_drain_pkg.sv
// Shared types and sizing helpers for the output feature drain.
package o_feature_drain_pkg;

  typedef enum logic [1:0] {IDLE, FILL, SEND, FIN} state_t;

  function automatic int calc_wpb(int bus_w, int feat_w);
    return bus_w / (2 * feat_w);
  endfunction

  // Guards the single-lane case where $clog2 would give a zero-width index.
  function automatic int lane_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WPB    = calc_wpb(128, 8);
  localparam int LANE_W = $clog2(WPB);
  localparam int RD_LAT = 1;

endpackage

// File: rtl/o_feature_drain_if.sv
// Feature-memory read port plus outbound beat bus of the drain.
interface o_feature_drain_if #(
  parameter int FEATURE_WIDTH = 8,
  parameter int BUS_WIDTH     = 128,
  parameter int ADDR_WIDTH    = 16
);
  logic                       rd_en;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic                       rd_sel;
  logic [2*FEATURE_WIDTH-1:0] rd_data;
  logic [BUS_WIDTH-1:0]       o_data;
  logic                       o_valid;
  logic                       o_ready;
  logic                       o_last;

  modport master (
    output rd_en, rd_addr, rd_sel, o_data, o_valid, o_last,
    input  rd_data, o_ready
  );
  modport slave (
    input  rd_en, rd_addr, rd_sel, o_data, o_valid, o_last,
    output rd_data, o_ready
  );
endinterface

// File: rtl/o_feature_drain_beat_pack.sv
// Lane register that assembles one outbound beat; full doubles as the beat-valid flag.
module o_beat_pack
  import o_feature_drain_pkg::*;
#(
  parameter int NUM_LANES = WPB,
  parameter int VEC_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              wr,
  input  logic                              wr_last,
  input  logic [VEC_W-1:0]                  wr_data,
  output logic [NUM_LANES-1:0][VEC_W-1:0]   lanes,
  output logic                              full
);
  localparam int LW = lane_w(NUM_LANES);

  logic [LW-1:0] wr_lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_lane <= '0;
      full    <= 1'b0;
    end else if (clr) begin
      wr_lane <= '0;
      full    <= 1'b0;
    end else if (wr) begin
      wr_lane <= wr_lane + 1'b1;
      if (wr_last) full <= 1'b1;
    end
  end

  // Clearing on beat start leaves unwritten lanes of a short final beat at zero.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [VEC_W-1:0] q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              q <= '0;
      else if (clr)                          q <= '0;
      else if (wr && (wr_lane == LW'(i)))    q <= wr_data;
    end
    assign lanes[i] = q;
  end

endmodule

// File: rtl/o_feature_drain.sv
// Reads output feature words, packs them into bus beats and streams them out.
module o_feature_drain
  import o_feature_drain_pkg::*;
#(
  parameter int FEATURE_WIDTH = 8,
  parameter int BUS_WIDTH     = 128,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           word_count,
  input  logic                  mem_sel,
  o_feature_drain_if.master     bus,
  output logic                  busy,
  output logic                  done
);
  localparam int NUM_LANES = calc_wpb(BUS_WIDTH, FEATURE_WIDTH);
  localparam int VEC_W     = 2 * FEATURE_WIDTH;
  localparam int LW        = lane_w(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [LW-1:0]         iss_q, iss_d;
  logic                  rd_en_d, rd_sel_q, rd_sel_d;
  logic                  o_last_q, o_last_d, busy_q, busy_d, done_q, done_d;
  logic [RD_LAT:0]       vld_pipe;
  logic                  cap, cap_last, hs, beat_clr, full;
  logic [NUM_LANES-1:0][VEC_W-1:0] lanes;

  // vld_pipe[0] is the live read strobe; vld_pipe[RD_LAT] marks returning data.
  assign cap      = vld_pipe[RD_LAT];
  assign cap_last = cap && !vld_pipe[0];
  assign hs       = full && bus.o_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (word_count == 16'd0) ? FIN : FILL;
      FILL: if (cap_last) state_nx = SEND;
      SEND: if (hs) state_nx = (rem_q != 16'd0) ? FILL : FIN;
      FIN:  if (done_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rem counts words not yet issued, so it reaches zero with the last read.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_sel_d  = rd_sel_q;
    rem_d     = rem_q;
    iss_d     = iss_q;
    o_last_d  = o_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    beat_clr  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        busy_d   = 1'b1;
        rd_sel_d = mem_sel;
        beat_clr = 1'b1;
        o_last_d = 1'b0;
        rem_d    = 16'd0;
        if (word_count != 16'd0) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_addr;
          rem_d     = word_count - 16'd1;
          iss_d     = '0;
        end
      end
      FILL: begin
        if (vld_pipe[0] && (iss_q != LAST_LANE) && (rem_q != 16'd0)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rem_d     = rem_q - 16'd1;
          iss_d     = iss_q + 1'b1;
        end
        if (cap_last) o_last_d = (rem_q == 16'd0);
      end
      SEND: if (hs) begin
        beat_clr = 1'b1;
        o_last_d = 1'b0;
        if (rem_q != 16'd0) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rem_d     = rem_q - 16'd1;
          iss_d     = '0;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      FIN: if (!done_q) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      rd_addr_q <= '0;
      rd_sel_q  <= 1'b0;
      rem_q     <= '0;
      iss_q     <= '0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], rd_en_d};
      rd_addr_q <= rd_addr_d;
      rd_sel_q  <= rd_sel_d;
      rem_q     <= rem_d;
      iss_q     <= iss_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  o_beat_pack #(
    .NUM_LANES (NUM_LANES),
    .VEC_W     (VEC_W)
  ) u_pack (
    .clk     (clk),
    .rst     (rst),
    .clr     (beat_clr),
    .wr      (cap),
    .wr_last (cap_last),
    .wr_data (bus.rd_data),
    .lanes   (lanes),
    .full    (full)
  );

  assign bus.rd_en   = vld_pipe[0];
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_sel  = rd_sel_q;
  assign bus.o_data  = lanes;
  assign bus.o_valid = full;
  assign bus.o_last  = o_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_o_feature_drain.sv
// Directed bench for o_feature_drain with a queue-based beat/address model.
module tb_o_feature_drain;
  logic        clk, rst, start, mem_sel, busy, done;
  logic [15:0] base_addr, word_count;

  o_feature_drain_if #(.FEATURE_WIDTH(8), .BUS_WIDTH(128), .ADDR_WIDTH(16)) bus ();

  o_feature_drain #(.FEATURE_WIDTH(8), .BUS_WIDTH(128), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_sel(mem_sel), .bus(bus),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad, cyc;
  int exp_done_cyc, done_cnt, done_expect, t0;
  int rd_rise_cyc, valid_rise_cyc, hs_cyc;
  logic        exp_sel;
  logic [15:0]  addr_q[$], rd_log[$];
  logic [127:0] beat_q[$], beat_log[$];
  logic         last_q[$], last_log[$];
  logic         prev_valid, prev_rd, prev_stall, prev_hs_more, prev_last;
  logic [127:0] prev_data;

  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic s);
    return s ? a : (a ^ 16'hA5A5);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responds one cycle after the strobe; idle cycles return a marker.
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? mem_word(bus.rd_addr, bus.rd_sel) : 16'hDEAD;

  always @(negedge clk) if (rst) begin
    logic [15:0]  ea;
    logic [127:0] eb;
    logic         el;
    if (bus.rd_en) begin
      rd_log.push_back(bus.rd_addr);
      if (!prev_rd) rd_rise_cyc = cyc;
      check("read_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) begin
        ea = addr_q.pop_front();
        check("rd_addr", bus.rd_addr, ea);
      end
      check("rd_sel", bus.rd_sel, exp_sel);
      check("rd_en_in_send", bus.o_valid, 0);
    end
    if (prev_hs_more) check("next_beat_rd", bus.rd_en, 1);
    if (prev_stall) begin
      check("hold_valid", bus.o_valid, 1);
      check("hold_data", bus.o_data, prev_data);
      check("hold_last", bus.o_last, prev_last);
    end
    if (bus.o_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_hs_more = 1'b0;
    if (bus.o_valid && bus.o_ready) begin
      beat_log.push_back(bus.o_data);
      last_log.push_back(bus.o_last);
      hs_cyc = cyc;
      check("beat_expected", beat_q.size() != 0, 1);
      if (beat_q.size() != 0) begin
        eb = beat_q.pop_front();
        el = last_q.pop_front();
        check("beat_data", bus.o_data, eb);
        check("beat_last", bus.o_last, el);
      end
      if (bus.o_last) exp_done_cyc = cyc + 1;
      else            prev_hs_more = 1'b1;
    end
    if (done) begin
      done_cnt++;
      check("done_cycle", cyc, exp_done_cyc);
      check("done_busy", busy, 0);
    end
    prev_valid = bus.o_valid;
    prev_rd    = bus.rd_en;
    prev_stall = bus.o_valid && !bus.o_ready;
    prev_data  = bus.o_data;
    prev_last  = bus.o_last;
  end

  // Model: beat b holds words base+8b..base+8b+7, zero past word_count.
  task automatic launch(input logic [15:0] base, input logic [15:0] wc, input logic sel);
    logic [127:0] beat;
    int nb;
    nb = (int'(wc) + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int k = 0; k < 8; k++)
        if (b * 8 + k < int'(wc)) beat[16*k +: 16] = mem_word(base + 16'(b * 8 + k), sel);
      beat_q.push_back(beat);
      last_q.push_back(b == nb - 1);
    end
    for (int i = 0; i < int'(wc); i++) addr_q.push_back(base + 16'(i));
    exp_sel = sel; exp_done_cyc = -1; done_expect++;
    rd_log.delete(); beat_log.delete(); last_log.delete();
    base_addr = base; word_count = wc; mem_sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    if (wc == 16'd0) exp_done_cyc = t0 + 1;
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin @(posedge clk); #1; n++; end
    check("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int v, n, dc;
    n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0; done_expect = 0;
    exp_done_cyc = -1; exp_sel = 1'b0; rd_rise_cyc = 0; valid_rise_cyc = 0; hs_cyc = 0;
    prev_valid = 0; prev_rd = 0; prev_stall = 0; prev_hs_more = 0; prev_last = 0; prev_data = '0;
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; mem_sel = 1'b0;
    bus.o_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_rd_sel", bus.rd_sel, 0);
    check("rst_o_data", bus.o_data, 0);
    check("rst_o_valid_last", {bus.o_valid, bus.o_last}, 0);
    check("rst_busy_done", {busy, done}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // One full beat, memory 1, word == address.
    launch(16'h0010, 16'd8, 1'b1);
    wait_done(40);
    check("t1_beats", beat_log.size(), 1);
    check("t1_beat", beat_log[0], 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    check("t1_last", last_log[0], 1);
    check("t1_first_rd", rd_rise_cyc, t0);
    check("t1_valid_lat", valid_rise_cyc - t0, 9);
    check("t1_rd_sel_after", bus.rd_sel, 1);

    // Eleven words: full beat then three-lane partial; inputs disturbed mid-run.
    launch(16'h0000, 16'd11, 1'b1);
    base_addr = 16'h5555; word_count = 16'd3; mem_sel = 1'b0;
    wait_done(80);
    check("t2_reads", rd_log.size(), 11);
    check("t2_beats", beat_log.size(), 2);
    check("t2_beat0", beat_log[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("t2_beat1", beat_log[1], 128'h0000_0000_0000_0000_0000_000A_0009_0008);
    check("t2_lasts", {last_log[0], last_log[1]}, 2'b01);

    // Back-pressure for five cycles after valid rises.
    bus.o_ready = 1'b0;
    launch(16'h0100, 16'd8, 1'b0);
    n = 0;
    while (!bus.o_valid && n < 30) begin @(posedge clk); #1; n++; end
    check("t3_valid_seen", bus.o_valid, 1);
    v = cyc;
    repeat (5) @(posedge clk);
    #1 bus.o_ready = 1'b1;
    wait_done(20);
    check("t3_accept_cycle", hs_cyc - v, 5);

    // Address wrap.
    launch(16'hFFFE, 16'd4, 1'b0);
    wait_done(40);
    check("t4_reads", rd_log.size(), 4);
    check("t4_addrs", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 64'hFFFE_FFFF_0000_0001);

    // Zero-length transfer; a start while busy must not launch anything.
    dc = done_cnt;
    launch(16'h0040, 16'd0, 1'b1);
    word_count = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_done_c2", {done, busy}, 2'b10);
    repeat (12) @(posedge clk); #1;
    check("t5_no_reads", rd_log.size(), 0);
    check("t5_no_beats", beat_log.size(), 0);
    check("t5_one_done", done_cnt - dc, 1);

    // Reset during FILL abandons the transfer silently.
    launch(16'h0200, 16'd16, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rd", {bus.rd_en, bus.rd_addr, bus.rd_sel}, 0);
    check("t6_o", {bus.o_valid, bus.o_last, bus.o_data}, 0);
    check("t6_busy_done", {busy, done}, 0);
    addr_q.delete(); beat_q.delete(); last_q.delete();
    exp_done_cyc = -1; done_expect--;
    prev_valid = 0; prev_rd = 0; prev_stall = 0; prev_hs_more = 0;
    dc = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("t6_no_done", done_cnt - dc, 0);
    launch(16'h0300, 16'd16, 1'b1);
    wait_done(80);
    check("t6_beats", beat_log.size(), 2);

    check("left_reads", addr_q.size(), 0);
    check("left_beats", beat_q.size(), 0);
    check("done_total", done_cnt, done_expect);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1);
  end

endmodule

// File: doc/o_feature_drain.md
# o_feature_drain

Transmit-side counterpart to the input feature fetch path. After a CLP pass completes, it reads output feature words from one of the two output feature memories and packs them into 128-bit beats. It then streams the beats to the external data bus with a valid/ready handshake. It sits between the output feature unit's read port and the outbound bus, replacing word-at-a-time ARM readout.

## Interface
Parameters:
- FEATURE_WIDTH, 8, half-width of one memory word; a word is 2*FEATURE_WIDTH bits.
- BUS_WIDTH, 128, outbound beat width; must be a multiple of 2*FEATURE_WIDTH.
- ADDR_WIDTH, 16, feature memory word address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; sampled on start.
- word_count  in  16  number of words to send; sampled on start.
- mem_sel  in  1  which output memory to read (0/1); sampled on start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_WIDTH  memory read address.
- rd_sel  out  1  registered copy of mem_sel.
- rd_data  in  2*FEATURE_WIDTH  read data, valid exactly 1 cycle after rd_en.
- o_data  out  BUS_WIDTH  packed beat.
- o_valid  out  1  beat valid.
- o_ready  in  1  bus accepts beat.
- o_last  out  1  marks the final beat of a transfer.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- WPB = BUS_WIDTH/(2*FEATURE_WIDTH) = 8 words per beat.
- Word k of a beat occupies o_data[16k+15:16k]; the lowest address goes in the lowest lane.
- FSM states:
  - IDLE: start goes to FILL, or to FIN if word_count==0.
  - FILL: issues up to WPB reads, one per cycle, and captures each returned word into its lane. Goes to SEND once the last issued word of the beat has been captured.
  - SEND: holds o_valid. On o_valid&&o_ready it goes to FILL if words remain, otherwise to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Partial final beat: lanes beyond the remaining words are driven to 0. o_last=1 on the final beat only.
- rd_addr increments by 1 per read and wraps modulo 2^ADDR_WIDTH.
- Remaining-word counter is 16 bits. Beats per transfer = ceil(word_count/8).
- start while busy is ignored. Changes to base_addr, word_count or mem_sel during a transfer have no effect.
- o_data, o_valid and o_last stay stable while o_valid=1 and o_ready=0.
- Reset values: rd_en=0, rd_addr=0, rd_sel=0, o_data=0, o_valid=0, o_last=0, busy=0, done=0, FSM=IDLE. Reset mid-transfer abandons the transfer and emits no done.

## Timing
- All outputs are registered.
- Start is sampled at edge 0. For a full beat:
  - rd_en is high in cycles 1–8 with addresses base..base+7.
  - rd_data arrives in cycles 2–9 and is captured at the end of each.
  - o_valid rises in cycle 10.
- When a beat handshakes in cycle t with words remaining, the next beat's first rd_en is in cycle t+1.
- After the final handshake in cycle t: done=1 and busy=0 in cycle t+1. The FSM is in IDLE and can accept start in cycle t+2.
- word_count==0: busy=1 in cycle 1, done=1 and busy=0 in cycle 2, no rd_en and no o_valid.
- rd_en is never asserted while in SEND. No read is issued beyond word_count.

## Structure
- Shared package holds:
  - WPB derivation.
  - State enum: IDLE, FILL, SEND, FIN.
  - Lane-index width localparam, $clog2(WPB).
- One natural sub-module: o_beat_pack. It is a lane register with a write-lane index, a clear-to-zero on beat start, and a full flag. The top level holds the FSM, the address counter and the remaining-word counter.

## Test plan
- word_count=8, base=0x0010, mem_sel=1, o_ready=1, memory holds word=address:
  - Exactly one beat, 0x0017_0016_…_0011_0010, o_last=1.
  - rd_sel=1 throughout; done 1 cycle after the handshake.
- word_count=11, base=0:
  - Two beats; the second is lanes 0–2 = 0x0008,0x0009,0x000A with lanes 3–7 = 0, o_last only on the second.
  - Exactly 11 rd_en cycles.
- o_ready low for 5 cycles after o_valid rises:
  - o_data, o_valid and o_last stay constant and no rd_en is asserted.
  - The beat is accepted on the 6th cycle.
- base=0xFFFE, word_count=4: rd_addr sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- word_count=0:
  - No rd_en and no o_valid; done in cycle 2.
  - A second start pulsed while busy in the previous transfer causes no extra transfer.
- rst asserted during FILL of a 16-word transfer:
  - All outputs return to their reset values immediately and no done pulse is emitted.
  - A new start after release completes normally.
